spi_cmd_master: RTL and testbench



---
 rtl/spi_cmd_master.sv | 153 +++++++++++++++
 tb/tb_spi_cmd_master.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_master.sv
// spi_cmd_master: FIFO-fed SPI command master with programmable bit order, sck rate and frame timing
module spi_cmd_master #(
  parameter int CODE_W     = 6,
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 16,
  parameter int CLK_DIV    = 5,
  parameter int LEAD_HP    = 4,
  parameter int TRAIL_HP   = 4,
  parameter int GAP_HP     = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                             clk_50M,
  input  logic                             rst_n,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  logic [CODE_W-1:0]                cmd_code,
  input  logic [ADDR_W-1:0]                cmd_addr,
  input  logic [DATA_W-1:0]                cmd_data,
  input  logic                             cfg_msb_first,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [CODE_W+ADDR_W+DATA_W-1:0]  rsp_data,
  output logic                             rsp_overflow,
  input  logic                             ovf_clr,
  output logic                             busy,
  output logic                             sck,
  output logic                             mosi,
  output logic                             cs_n,
  input  logic                             miso
);
  localparam int FRAME_W = CODE_W + ADDR_W + DATA_W;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = $clog2(CLK_DIV);
  localparam int IW = $clog2(FRAME_W);
  localparam int HP_MAX = (2*FRAME_W > LEAD_HP) && (2*FRAME_W > TRAIL_HP) && (2*FRAME_W > GAP_HP) ? 2*FRAME_W :
                          (LEAD_HP > TRAIL_HP) && (LEAD_HP > GAP_HP) ? LEAD_HP :
                          TRAIL_HP > GAP_HP ? TRAIL_HP : GAP_HP;
  localparam int HW = $clog2(HP_MAX);
  localparam logic [AW:0] FULL = FIFO_DEPTH[AW:0];
  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;
  state_t state, state_nx;
  logic [DW-1:0] div_cnt;
  logic [HW-1:0] hp_cnt, hp_lim;
  logic tick, done, pop, push, xfer, msb;
  logic [FRAME_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [FRAME_W-1:0] head, tx, rx;
  logic [IW-1:0] k, nk, cur_idx, nxt_idx;

  assign tick = div_cnt == DW'(CLK_DIV-1);
  assign head = fifo_mem[rd_ptr];
  assign cmd_ready = count != FULL;
  assign push = cmd_valid && cmd_ready;
  assign pop = state == IDLE && count != '0;
  assign busy = state != IDLE || count != '0;
  assign xfer = state == TRAIL && done;
  assign k = hp_cnt[IW:1];
  assign nk = k + IW'(1);
  assign cur_idx = msb ? IW'(FRAME_W-1) - k : k;
  assign nxt_idx = msb ? IW'(FRAME_W-1) - nk : nk;

  // Per-state half-period limit and next-state selection
  always_comb begin
    hp_lim = state == LEAD ? HW'(LEAD_HP-1) : state == SHIFT ? HW'(2*FRAME_W-1) :
             state == TRAIL ? HW'(TRAIL_HP-1) : HW'(GAP_HP-1);
    done = tick && hp_cnt == hp_lim;
    state_nx = state;
    case (state)
      IDLE:    state_nx = pop ? LEAD : IDLE;
      LEAD:    state_nx = done ? SHIFT : LEAD;
      SHIFT:   state_nx = done ? TRAIL : SHIFT;
      TRAIL:   state_nx = done ? GAP : TRAIL;
      default: state_nx = done ? IDLE : state;
    endcase
  end

  // State register
  always_ff @(posedge clk_50M or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;

  // Half-period tick divider and half-period counter, both restarted on every state entry
  always_ff @(posedge clk_50M or negedge rst_n)
    if (!rst_n) begin
      div_cnt <= '0;
      hp_cnt <= '0;
    end else if (state_nx != state) begin
      div_cnt <= '0;
      hp_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
      hp_cnt <= hp_cnt + HW'(1);
    end else div_cnt <= div_cnt + DW'(1);

  // Command FIFO storage; emptiness is governed by the reset pointers
  always_ff @(posedge clk_50M)
    if (push) fifo_mem[wr_ptr] <= {cmd_code, cmd_addr, cmd_data};

  // Command FIFO pointers and occupancy
  always_ff @(posedge clk_50M or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end

  // SPI pins and shift datapath: sck falls mid-bit with miso capture, rises with the next mosi bit
  always_ff @(posedge clk_50M or negedge rst_n)
    if (!rst_n) begin
      tx <= '0;
      rx <= '0;
      msb <= 1'b0;
      sck <= 1'b1;
      mosi <= 1'b0;
      cs_n <= 1'b1;
    end else begin
      if (pop) begin
        tx <= head;
        msb <= cfg_msb_first;
        cs_n <= 1'b0;
        mosi <= cfg_msb_first ? head[FRAME_W-1] : head[0];
      end
      if (state == SHIFT && tick) begin
        if (!hp_cnt[0]) begin
          sck <= 1'b0;
          rx[cur_idx] <= miso;
        end else begin
          sck <= 1'b1;
          mosi <= done ? 1'b0 : tx[nxt_idx];
        end
      end
      if (xfer) cs_n <= 1'b1;
    end

  // Response register with handshake and sticky overflow (set beats clear)
  always_ff @(posedge clk_50M or negedge rst_n)
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_overflow <= 1'b0;
    end else begin
      if (xfer) begin
        rsp_data <= rx;
        rsp_valid <= 1'b1;
      end else if (rsp_ready) rsp_valid <= 1'b0;
      rsp_overflow <= (xfer && rsp_valid && !rsp_ready) || (rsp_overflow && !ovf_clr);
    end
endmodule

// File: tb/tb_spi_cmd_master.sv
// tb_spi_cmd_master: directed and randomized frame checks against a bit-order/timing reference model
module tb_spi_cmd_master;
  localparam int FW = 32;
  localparam int FRAME_CYC = 360;
  localparam int GAP_CYC = 61;
  localparam int BIT_CYC = 10;
  logic clk_50M = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0;
  logic cfg_msb_first = 1'b0;
  logic rsp_ready = 1'b0;
  logic ovf_clr = 1'b0;
  logic [5:0] cmd_code = '0;
  logic [9:0] cmd_addr = '0;
  logic [15:0] cmd_data = '0;
  logic cmd_ready, rsp_valid, rsp_overflow, busy, sck, mosi, cs_n, miso;
  logic [31:0] rsp_data;
  int n_chk = 0;
  int n_fail = 0;
  logic lb = 1'b0;
  logic msb_cur = 1'b0;
  logic flip_mid = 1'b0;
  logic rdy_end = 1'b0;
  logic [31:0] mw = '0;
  int nfall = 0;
  logic psck = 1'b1;

  spi_cmd_master dut (
    .clk_50M(clk_50M), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_code(cmd_code), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cfg_msb_first(cfg_msb_first),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_overflow(rsp_overflow),
    .ovf_clr(ovf_clr), .busy(busy), .sck(sck), .mosi(mosi), .cs_n(cs_n), .miso(miso)
  );

  always #10 clk_50M = ~clk_50M;

  // Slave model: counts sck falls in the current frame to pick which miso bit to present
  always @(negedge clk_50M) begin
    if (cs_n) nfall = 0;
    else if (psck && !sck) nfall = nfall + 1;
    psck = sck;
  end

  // Slave presents mw bit at the same frame index as the mosi bit of this slot, or loops mosi back
  always_comb begin
    miso = 1'b0;
    if (lb) miso = mosi;
    else if (nfall < FW) miso = 1'(mw >> (msb_cur ? FW-1-nfall : nfall));
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_push(input logic [31:0] w, output logic acc);
    @(negedge clk_50M);
    cmd_valid = 1'b1;
    {cmd_code, cmd_addr, cmd_data} = w;
    acc = cmd_ready;
  endtask

  task automatic push1(input string tag, input logic [31:0] w);
    logic acc;
    drive_push(w, acc);
    @(negedge clk_50M);
    cmd_valid = 1'b0;
    chk({tag, "_acc"}, acc, 1);
  endtask

  task automatic wait_idle(input string tag);
    int t = 0;
    while (busy && t < 1000) begin
      @(negedge clk_50M);
      t++;
    end
    chk({tag, "_idle"}, busy, 0);
  endtask

  task automatic capture(output int hi, output int low, output int nf, output int bad,
                         output logic [31:0] bits, output logic first);
    int last = 0;
    logic ps = 1'b1;
    hi = 0; low = 0; nf = 0; bad = 0; bits = '0;
    while (cs_n && hi < 2000) begin
      @(negedge clk_50M);
      hi++;
    end
    first = mosi;
    while (!cs_n && low < 1000) begin
      if (ps && !sck) begin
        if (nf > 0 && low - last != BIT_CYC) bad++;
        if (nf < FW) bits = bits | (32'(mosi) << nf);
        last = low;
        nf++;
        if (flip_mid && nf == 5) cfg_msb_first = !cfg_msb_first;
      end
      ps = sck;
      if (rdy_end && low == FRAME_CYC-1) rsp_ready = 1'b1;
      @(negedge clk_50M);
      low++;
    end
    if (rdy_end) rsp_ready = 1'b0;
  endtask

  task automatic frame_chk(input string tag, input logic [31:0] w, input logic m,
                           input logic [31:0] rsp_exp, input int exp_hi);
    int hi, low, nf, bad;
    logic [31:0] bits, rev;
    logic first, exp_first;
    rev = {<<{w}};
    exp_first = m ? w[31] : w[0];
    capture(hi, low, nf, bad, bits, first);
    if (exp_hi >= 0) chk({tag, "_gap"}, hi, exp_hi);
    chk({tag, "_cs_low"}, low, FRAME_CYC);
    chk({tag, "_nfall"}, nf, FW);
    chk({tag, "_fall_spacing_err"}, bad, 0);
    chk({tag, "_mosi_bits"}, bits, m ? rev : w);
    chk({tag, "_first_bit"}, first, exp_first);
    chk({tag, "_rsp_valid"}, rsp_valid, 1);
    chk({tag, "_rsp_data"}, rsp_data, rsp_exp);
  endtask

  task automatic consume(input string tag);
    rsp_ready = 1'b1;
    @(negedge clk_50M);
    rsp_ready = 1'b0;
    chk({tag, "_rsp_clear"}, rsp_valid, 0);
  endtask

  initial begin
    logic acc;
    logic [31:0] w, w2;
    logic [31:0] q[$];
    int t, lows;
    repeat (2) @(negedge clk_50M);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_sck", sck, 1);
    chk("rst_mosi", mosi, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_ovf", rsp_overflow, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cmd_ready, 1);
    rst_n = 1'b1;

    lb = 1'b0; cfg_msb_first = 1'b0; msb_cur = 1'b0; mw = $urandom;
    w = {6'd24, 10'd0, 16'h55ED};
    push1("t1", w);
    frame_chk("t1", w, 1'b0, mw, -1);
    chk("t1_busy_gap", busy, 1);
    consume("t1");

    lb = 1'b1; cfg_msb_first = 1'b1; msb_cur = 1'b1;
    w = 32'hA5C3_0F1E;
    push1("t2", w);
    frame_chk("t2", w, 1'b1, w, -1);
    consume("t2");

    wait_idle("t3");
    cfg_msb_first = 1'($urandom); msb_cur = cfg_msb_first; rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      w = $urandom;
      drive_push(w, acc);
      chk("t3_acc", acc, 1);
      q.push_back(w);
    end
    @(negedge clk_50M);
    chk("t3_full_ready", cmd_ready, 0);
    cmd_valid = 1'b0;
    w = q.pop_front();
    t = 0;
    while (!cs_n && t < 1000) begin
      @(negedge clk_50M);
      t++;
    end
    chk("t3_f0_rsp", rsp_data, w);
    for (int i = 1; i < 5; i++) begin
      w = q.pop_front();
      frame_chk("t3", w, msb_cur, w, GAP_CYC);
    end
    t = 0;
    while (busy && t < 200) begin
      @(negedge clk_50M);
      t++;
    end
    chk("t3_busy_drop", t, 60);
    chk("t3_ready_back", cmd_ready, 1);
    rsp_ready = 1'b0;

    lb = 1'b0; cfg_msb_first = 1'($urandom); msb_cur = cfg_msb_first;
    w = $urandom; w2 = $urandom; mw = $urandom;
    drive_push(w, acc);
    drive_push(w2, acc);
    @(negedge clk_50M);
    cmd_valid = 1'b0;
    flip_mid = 1'b1;
    frame_chk("t4a", w, msb_cur, mw, -1);
    flip_mid = 1'b0;
    msb_cur = cfg_msb_first;
    chk("t4a_ovf", rsp_overflow, 0);
    mw = $urandom;
    frame_chk("t4b", w2, msb_cur, mw, -1);
    chk("t4b_ovf", rsp_overflow, 1);
    ovf_clr = 1'b1;
    @(negedge clk_50M);
    ovf_clr = 1'b0;
    chk("t4_ovf_clr", rsp_overflow, 0);
    chk("t4_valid_kept", rsp_valid, 1);

    w = $urandom; mw = $urandom;
    push1("t5", w);
    rdy_end = 1'b1;
    frame_chk("t5", w, msb_cur, mw, -1);
    rdy_end = 1'b0;
    chk("t5_ovf", rsp_overflow, 0);
    @(negedge clk_50M);
    chk("t5_valid_hold", rsp_valid, 1);

    w = $urandom; w2 = $urandom; mw = $urandom;
    drive_push(w, acc);
    drive_push(w2, acc);
    @(negedge clk_50M);
    cmd_valid = 1'b0;
    t = 0;
    while (nfall != 10 && t < 3000) begin
      @(negedge clk_50M);
      t++;
    end
    chk("t6_reached_bit10", nfall, 10);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_cs_n", cs_n, 1);
    chk("t6_sck", sck, 1);
    chk("t6_mosi", mosi, 0);
    chk("t6_rsp_valid", rsp_valid, 0);
    chk("t6_busy", busy, 0);
    chk("t6_ready", cmd_ready, 1);
    @(negedge clk_50M);
    rst_n = 1'b1;
    lows = 0;
    repeat (100) begin
      @(negedge clk_50M);
      if (!cs_n) lows++;
    end
    chk("t6_no_frame", lows, 0);

    for (int i = 0; i < 4; i++) begin
      lb = 1'($urandom); cfg_msb_first = 1'($urandom); msb_cur = cfg_msb_first;
      w = $urandom; mw = $urandom;
      push1("rnd", w);
      frame_chk("rnd", w, msb_cur, lb ? w : mw, -1);
      consume("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
